// File: rtl/fp_pkg.sv
`default_nettype none
// fp_pkg: binary32 field widths, special encodings, unpacked-operand type and
// the sequencer state encoding shared by the iterative FP add/sub blocks.
package fp_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int EXT_W     = 27;
  localparam int ALIGN_CAP = 26;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [EXT_W-1:0] man;
  } fp_unp_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_SUB    = 3'd3,
    S_NORM   = 3'd4,
    S_ROUND  = 3'd5,
    S_DONE   = 3'd6
  } fp_state_t;

  // Zero exponent (zero or denormal) flushes to a signed zero with empty mantissa.
  function automatic fp_unp_t fp_unpack(input logic [31:0] w);
    fp_unp_t u;
    u.sign = w[31];
    u.exp  = w[30:23];
    u.man  = (w[30:23] == 8'd0) ? '0 : {1'b1, w[MAN_W-1:0], 3'b000};
    return u;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_sub_seq_if.sv
`default_nettype none
// fp_sub_seq_if: operand/result valid-ready bus of the iterative subtractor.
interface fp_sub_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_sub_a;
  logic [31:0] fp_sub_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_sub_r;

  modport master (
    output in_valid, fp_sub_a, fp_sub_b, out_ready,
    input  in_ready, out_valid, fp_sub_r
  );

  modport slave (
    input  in_valid, fp_sub_a, fp_sub_b, out_ready,
    output in_ready, out_valid, fp_sub_r
  );
endinterface
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// fp_round_rne: combinational round-to-nearest-even of a normalised 27-bit
// mantissa (24 bits + guard/round/sticky) and packing to binary32.
module fp_round_rne
  import fp_pkg::*;
(
  input  wire logic        i_sign,
  input  wire logic [9:0]  i_exp,
  input  wire logic [26:0] i_man,
  output logic      [31:0] o_word
);

  logic        w_up;
  logic [24:0] w_sum;
  logic [9:0]  w_exp;
  logic [22:0] w_frac;

  always_comb begin
    w_up   = i_man[2] & (i_man[1] | i_man[0] | i_man[3]);
    w_sum  = {1'b0, i_man[26:3]} + {24'd0, w_up};
    w_exp  = i_exp + {9'd0, w_sum[24]};
    w_frac = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
    if (w_exp >= 10'd255) begin
      o_word = i_sign ? NEG_INF : POS_INF;
    end else begin
      o_word = {i_sign, w_exp[7:0], w_frac};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_sub_seq.sv
`default_nettype none
// fp_sub_seq: iterative binary32 subtractor r = a - b; alignment and
// normalisation advance one bit per cycle behind valid/ready handshakes.
module fp_sub_seq
  import fp_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   rst,
  fp_sub_seq_if.slave bus
);

  fp_state_t   r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_res;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sign;
  logic        r_eff_sub;
  logic [9:0]  r_exp;
  logic [26:0] r_mx;
  logic [26:0] r_my;
  logic [4:0]  r_cnt;

  fp_unp_t     w_ua;
  fp_unp_t     w_ub;
  fp_unp_t     w_x;
  fp_unp_t     w_y;
  logic [7:0]  w_diff;
  logic [4:0]  w_d;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_a_inf;
  logic        w_b_inf;
  logic        w_special;
  logic [31:0] w_spec_word;
  logic [27:0] w_sum;
  logic [31:0] w_round;

  always_comb begin
    w_ua = fp_unpack(r_a);
    w_ub = fp_unpack(r_b);
    if ({w_ub.exp, w_ub.man} > {w_ua.exp, w_ua.man}) begin
      w_x = w_ub;
      w_y = w_ua;
    end else begin
      w_x = w_ua;
      w_y = w_ub;
    end
    w_diff = w_x.exp - w_y.exp;
    w_d    = (w_diff > 8'(ALIGN_CAP)) ? 5'(ALIGN_CAP) : w_diff[4:0];

    // r_b already carries the inverted sign, so specials see effective signs.
    w_a_nan = (&r_a[30:23]) & (|r_a[22:0]);
    w_b_nan = (&r_b[30:23]) & (|r_b[22:0]);
    w_a_inf = (&r_a[30:23]) & ~(|r_a[22:0]);
    w_b_inf = (&r_b[30:23]) & ~(|r_b[22:0]);

    w_special   = 1'b1;
    w_spec_word = QNAN;
    if (w_a_nan | w_b_nan) begin
      w_spec_word = QNAN;
    end else if (w_a_inf & w_b_inf) begin
      w_spec_word = (r_a[31] == r_b[31]) ? r_a : QNAN;
    end else if (w_a_inf) begin
      w_spec_word = r_a;
    end else if (w_b_inf) begin
      w_spec_word = r_b;
    end else if ((w_ua.man == 27'd0) && (w_ub.man == 27'd0)) begin
      w_spec_word = {r_a[31] & r_b[31], 31'd0};
    end else begin
      w_special = 1'b0;
    end

    w_sum = r_eff_sub ? ({1'b0, r_mx} - {1'b0, r_my})
                      : ({1'b0, r_mx} + {1'b0, r_my});
  end

  fp_round_rne u_round (
    .i_sign (r_sign),
    .i_exp  (r_exp),
    .i_man  (r_mx),
    .o_word (w_round)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_res       <= 32'h0;
      r_a         <= 32'h0;
      r_b         <= 32'h0;
      r_sign      <= 1'b0;
      r_eff_sub   <= 1'b0;
      r_exp       <= 10'd0;
      r_mx        <= 27'd0;
      r_my        <= 27'd0;
      r_cnt       <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.fp_sub_a;
            r_b        <= {~bus.fp_sub_b[31], bus.fp_sub_b[30:0]};
            r_in_ready <= 1'b0;
            r_state    <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (w_special) begin
            r_res       <= w_spec_word;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_sign    <= w_x.sign;
            r_eff_sub <= w_x.sign ^ w_y.sign;
            r_exp     <= {2'b00, w_x.exp};
            r_mx      <= w_x.man;
            r_my      <= w_y.man;
            r_cnt     <= w_d;
            r_state   <= (w_d != 5'd0) ? S_ALIGN : S_SUB;
          end
        end
        S_ALIGN: begin
          r_my  <= {1'b0, r_my[26:2], r_my[1] | r_my[0]};
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state <= S_SUB;
          end
        end
        S_SUB: begin
          if (w_sum == 28'd0) begin
            r_res       <= 32'h0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_sum[27]) begin
            r_mx    <= {w_sum[27:2], w_sum[1] | w_sum[0]};
            r_exp   <= r_exp + 10'd1;
            r_state <= S_ROUND;
          end else begin
            r_mx    <= w_sum[26:0];
            r_state <= w_sum[26] ? S_ROUND : S_NORM;
          end
        end
        S_NORM: begin
          // Reaching exponent 0 would need a denormal; flush instead.
          if (r_exp == 10'd1) begin
            r_res       <= {r_sign, 31'd0};
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_mx  <= {r_mx[25:0], 1'b0};
            r_exp <= r_exp - 10'd1;
            if (r_mx[25]) begin
              r_state <= S_ROUND;
            end
          end
        end
        S_ROUND: begin
          r_res       <= w_round;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.fp_sub_r  = r_res;

endmodule
`default_nettype wire

// File: tb/tb_fp_sub_seq.sv
`default_nettype none
`timescale 1ns/1ps
// tb_fp_sub_seq: directed and random checks of fp_sub_seq against an
// exact-arithmetic binary32 subtraction model.
module tb_fp_sub_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_sub_seq_if bus ();

  fp_sub_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  // Exact model: operands become integers in units of 2^-150, then RNE.
  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]  bb;
    logic         sa, sb, sr, a_nan, b_nan, a_inf, b_inf;
    logic [299:0] ma, mb, mag, rem, half, tmp;
    logic [24:0]  m;
    int           p, e;
    bb    = b ^ 32'h8000_0000;
    sa    = a[31];
    sb    = bb[31];
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (bb[30:23] == 8'hFF) && (bb[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (bb[30:23] == 8'hFF) && (bb[22:0] == 0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (a_inf && b_inf) return (sa == sb) ? a : 32'h7FC0_0000;
    if (a_inf) return a;
    if (b_inf) return bb;
    if (a[30:23] == 0 && bb[30:23] == 0) return {sa & sb, 31'd0};
    ma = (a[30:23] == 0)  ? '0 : ({276'd0, 1'b1, a[22:0]}  << a[30:23]);
    mb = (bb[30:23] == 0) ? '0 : ({276'd0, 1'b1, bb[22:0]} << bb[30:23]);
    if (sa == sb) begin
      mag = ma + mb; sr = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; sr = sa;
    end else begin
      mag = mb - ma; sr = sb;
    end
    if (mag == 0) return 32'h0;
    p = 0;
    for (int i = 299; i >= 0; i--) begin
      if (mag[i]) begin p = i; break; end
    end
    e = p - 23;
    if (e < 1) return {sr, 31'd0};
    tmp  = mag >> e;
    m    = tmp[24:0];
    rem  = mag & ((300'd1 << e) - 300'd1);
    half = 300'd1 << (e - 1);
    if (rem > half || (rem == half && m[0])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e++; end
    if (e >= 255) return {sr, 8'hFF, 23'd0};
    return {sr, 8'(e), m[22:0]};
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    bus.fp_sub_a = a;
    bus.fp_sub_b = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("out_valid_wait", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat);
    launch(a, b);
    wait_valid(lat);
    r = bus.fp_sub_r;
    @(posedge clk); #1;
  endtask

  logic [31:0] d_a   [7] = '{32'h4040_0000, 32'h3F80_0000, 32'h8000_0000, 32'h3F80_0000,
                             32'h3F80_0000, 32'h7F80_0000, 32'h7F7F_FFFF};
  logic [31:0] d_b   [7] = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 32'h3380_0000,
                             32'h3300_0000, 32'h7F80_0000, 32'hFF7F_FFFF};
  logic [31:0] d_exp [7] = '{32'h4000_0000, 32'h0000_0000, 32'h8000_0000, 32'h3F7F_FFFF,
                             32'h3F80_0000, 32'h7FC0_0000, 32'h7F80_0000};
  int          d_lat [7] = '{4, 2, 1, 28, 29, 1, 3};

  logic [31:0] specials [6] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
                                32'hFF80_0000, 32'h7FC0_0001, 32'h0001_2345};

  initial begin
    logic [31:0] r, a, b;
    int          lat, e, delta;

    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.fp_sub_a = 32'h0;
    bus.fp_sub_b = 32'h0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result",    bus.fp_sub_r,           32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(d_a[i], d_b[i], r, lat);
      chk($sformatf("dir%0d_result", i), r, d_exp[i]);
      chk($sformatf("dir%0d_latency", i), 32'(lat), 32'(d_lat[i]));
    end

    // Backpressure: result and in_ready frozen while out_ready is low.
    bus.out_ready = 1'b0;
    launch(32'h4040_0000, 32'h3F80_0000);
    wait_valid(lat);
    chk("bp_result", bus.fp_sub_r, 32'h4000_0000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_result", bus.fp_sub_r, 32'h4000_0000);
      chk("bp_hold_valid",  {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready",    {31'd0, bus.in_ready},  32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {31'd0, bus.in_ready},  32'd1);
    chk("bp_release_valid",    {31'd0, bus.out_valid}, 32'd0);

    // Asynchronous reset in the middle of a long alignment.
    launch(32'h4B00_0000, 32'h3F80_0000);
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_valid",    {31'd0, bus.out_valid}, 32'd0);
    chk("abort_result",   bus.fp_sub_r,           32'h0);
    chk("abort_in_ready", {31'd0, bus.in_ready},  32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_valid_held", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(32'h4000_0000, 32'h3F80_0000, r, lat);
    chk("post_rst_result", r, 32'h3F80_0000);

    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0, 1: b = $urandom;
        2, 3: begin
          delta = int'($urandom_range(0, 4)) - 2;
          e = int'(a[30:23]) + delta;
          if (e < 1) e = 1;
          if (e > 254) e = 254;
          b = {1'($urandom), 8'(e), 23'($urandom)};
        end
        4: begin
          b = a ^ ($urandom & 32'h0000_00FF);
          if ($urandom_range(0, 1) == 1) b = b ^ 32'h8000_0000;
        end
        default: b = specials[$urandom_range(0, 5)];
      endcase
      run_op(a, b, r, lat);
      chk($sformatf("rand %08h-%08h", a, b), r, ref_sub(a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fp_sub_seq.md
# fp_sub_seq

Iterative single-precision (IEEE-754 binary32) subtractor computing fp_sub_r = fp_sub_a − fp_sub_b. It completes the add/subtract pair beside fp_add in the systolic processing-element datapath, used where a PE needs a difference rather than a sum. It trades throughput for area:
- one shift bit per cycle in the alignment and normalisation steps;
- valid/ready handshakes on both sides, so it can stall the array.

## Interface
- ALIGN_CAP, 26: maximum alignment shift; larger exponent differences collapse into sticky.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands (IDLE only).
- fp_sub_a  input  32  minuend, binary32.
- fp_sub_b  input  32  subtrahend, binary32.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- fp_sub_r  output  32  result, binary32.

## Operation
**Reset values:** rst low forces state IDLE, in_ready=1, out_valid=0, fp_sub_r=32'h0 and clears all internal registers.

**States:** IDLE, UNPACK, ALIGN, SUB, NORM, ROUND, DONE.

- **IDLE:** in_valid && in_ready captures a and b, and b's sign is inverted. Goes to UNPACK.
- **UNPACK:** operands with exponent 0 are flushed to signed zero. Operands are ordered so the larger |{exp,man}| is X. Hidden bit is prepended to form 24-bit mantissas, extended with guard/round/sticky to 27 bits. d = min(expX − expY, ALIGN_CAP). Specials go directly to DONE:
  - any NaN → 7FC00000;
  - (+inf) − (+inf) or (−inf) − (−inf) → 7FC00000;
  - one infinite operand → that infinity with its effective sign;
  - both operands zero → +0, except (−0) − (+0) = 80000000.
  - Otherwise: next state is ALIGN if d>0, else SUB.
- **ALIGN:** shifts Y right 1 bit per cycle, ORing shifted-out bits into sticky. Runs exactly d cycles.
- **SUB:** 28-bit magnitude add (signs equal after the b-inversion) or subtract X−Y (signs differ); sign = X sign.
  - Exact zero difference → +0, go to DONE.
  - Carry out → right shift 1 (sticky kept), exponent +1, go to ROUND.
  - Otherwise → NORM if the MSB is 0, else ROUND.
- **NORM:** left shift 1 per cycle with exponent −1 until the MSB is 1. If the exponent reaches 0 the result is flushed to signed zero and the state goes to DONE.
- **ROUND:** round-to-nearest-even on guard/round/sticky.
  - Mantissa overflow → exponent +1.
  - Exponent ≥ 255 → signed infinity.
  - Then pack the result and go to DONE.
- **DONE:** out_valid=1 and fp_sub_r is held stable. out_valid && out_ready → IDLE on the same edge.

**Rules:**
- No denormal outputs are ever produced.
- in_ready=0 outside IDLE; new operands are never accepted while busy.

## Timing
- Acceptance edge E0. out_valid rises after edge E0+3+d+n, where n = NORM cycles (0..25).
- Specials and zeros: out_valid rises after E0+1; zero difference after E0+2+d.
- Minimum normal latency is 3 cycles; maximum is 3+26+25.
- After an out handshake, in_ready=1 the next cycle: at most one result per 5 cycles for normal operands.
- out_ready held low stalls indefinitely in DONE with no change to fp_sub_r.
- rst low mid-operation aborts the operation: no out_valid and no partial result visible. First acceptance is possible on the first rising edge with rst high.

## Structure
- Shared package fp_pkg:
  - FP32 field widths;
  - constants QNAN=32'h7FC00000, POS_INF, NEG_INF;
  - unpacked-operand struct {sign, exp[7:0], man[26:0]};
  - state enum.
- Optional sub-module fp_round_rne, a combinational rounder on the 27-bit mantissa plus exponent. It is reusable by fp_add.

## Test plan
- 40400000 − 3F800000 → 40000000; out_valid exactly 4 cycles after acceptance.
- 3F800000 − 3F800000 → 00000000. 80000000 − 00000000 → 80000000 one cycle after acceptance.
- 3F800000 − 33800000 → 3F7FFFFF (NORM path). 3F800000 − 33000000 → 3F800000 (tie to even).
- 7F800000 − 7F800000 → 7FC00000. 7F7FFFFF − FF7FFFFF → 7F800000 (overflow).
- Backpressure: hold out_ready low 5 cycles after out_valid → fp_sub_r stable and in_ready=0 throughout. Release → in_ready=1 next cycle.
- Assert rst low during ALIGN of 4B000000 − 3F800000 → outputs zero immediately and out_valid never rises. Next op 40000000 − 3F800000 → 3F800000.
